// File: rtl/iob_dbus_split_pkg.sv
// Shared types and constants for the IOb data-bus address splitter.
package iob_dbus_split_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitRsp  = 2'd1,
    StLocalRsp = 2'd2
  } state_t;

  localparam int unsigned ERR_RDATA = 0;

  function automatic logic sel_mapped(input int unsigned sel, input int unsigned n_slaves);
    return sel < n_slaves;
  endfunction

endpackage

// File: rtl/iob_dbus_split_timer.sv
// Read timeout counter: cleared on a new read, counts while enabled, saturates at done.
module iob_dbus_split_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cke,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cke) begin
      if (clr) begin
        cnt <= '0;
      end else if (en && !done) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_dbus_split.sv
// Routes IOb data-bus requests to N_SLAVES targets by address, one outstanding read,
// with local error responses for unmapped reads and read timeouts.
module iob_dbus_split
  import iob_dbus_split_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_SLAVES = 3,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       cke_i,
  input  logic                       s_avalid_i,
  input  logic [ADDR_W-1:0]          s_addr_i,
  input  logic [DATA_W-1:0]          s_wdata_i,
  input  logic [DATA_W/8-1:0]        s_wstrb_i,
  output logic                       s_ready_o,
  output logic                       s_rvalid_o,
  output logic [DATA_W-1:0]          s_rdata_o,
  output logic                       s_rerr_o,
  output logic [N_SLAVES-1:0]        m_avalid_o,
  output logic [ADDR_W-1:0]          m_addr_o,
  output logic [DATA_W-1:0]          m_wdata_o,
  output logic [DATA_W/8-1:0]        m_wstrb_o,
  input  logic [N_SLAVES-1:0]        m_ready_i,
  input  logic [N_SLAVES-1:0]        m_rvalid_i,
  input  logic [N_SLAVES*DATA_W-1:0] m_rdata_i,
  output logic                       fault_o
);

  localparam int unsigned N_SEL = 1 << SEL_W;

  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic [SEL_W-1:0]    pend_sel;
  logic [N_SEL-1:0]    ready_ext;
  logic [N_SEL-1:0]    rvalid_ext;
  logic [N_SEL*DATA_W-1:0] rdata_ext;
  logic mapped, is_read, go, rsp_now, tmo, acc, tmr_done, waiting, local_rsp, fault;

  // Zero-extend slave vectors to the full select range so any sel value indexes safely.
  assign ready_ext  = N_SEL'(m_ready_i);
  assign rvalid_ext = N_SEL'(m_rvalid_i);
  assign rdata_ext  = (N_SEL*DATA_W)'(m_rdata_i);

  assign sel       = s_addr_i[ADDR_W-2 -: SEL_W];
  assign mapped    = sel_mapped(32'(sel), N_SLAVES);
  assign is_read   = (s_wstrb_i == '0);
  assign waiting   = (state == StWaitRsp);
  assign local_rsp = (state == StLocalRsp);
  assign rsp_now   = waiting && rvalid_ext[pend_sel];
  assign tmo       = waiting && !rsp_now && tmr_done;
  assign go        = (state == StIdle) || rsp_now;

  assign s_ready_o = go && (mapped ? ready_ext[sel] : 1'b1);
  assign acc       = s_avalid_i && s_ready_o;

  always_comb begin
    m_avalid_o = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      m_avalid_o[k] = mapped && s_avalid_i && go && (32'(sel) == k);
    end
  end

  assign m_addr_o  = s_addr_i;
  assign m_wdata_o = s_wdata_i;
  assign m_wstrb_o = s_wstrb_i;

  assign s_rvalid_o = rsp_now || tmo || local_rsp;
  assign s_rerr_o   = tmo || local_rsp;
  assign s_rdata_o  = rsp_now ? rdata_ext[32'(pend_sel)*DATA_W +: DATA_W] : DATA_W'(ERR_RDATA);
  assign fault_o    = fault;

  iob_dbus_split_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk_i),
    .rst_n(arst_i),
    .cke  (cke_i),
    .clr  (acc && mapped && is_read),
    .en   (waiting && !rsp_now),
    .done (tmr_done)
  );

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state    <= StIdle;
      pend_sel <= '0;
      fault    <= 1'b0;
    end else if (cke_i) begin
      if (acc && is_read && mapped) begin
        state    <= StWaitRsp;
        pend_sel <= sel;
      end else if (acc && is_read) begin
        state <= StLocalRsp;
      end else if (rsp_now || tmo || local_rsp) begin
        state <= StIdle;
      end
      // Unmapped writes are silently dropped but still flag the fault.
      if (tmo || local_rsp || (acc && !is_read && !mapped)) begin
        fault <= 1'b1;
      end
    end
  end

endmodule
